// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - multi-cycle multiply/divide unit (shift-add / restoring divide)
//
// Purpose : iterative WIDTH x WIDTH multiplier and WIDTH / WIDTH divider, one
//           iteration per clock, WIDTH iterations per operation.
// Macro   : MCYCLE_SIGNED_EN - when defined, Signed=1 selects two's-complement
//           operation; when undefined the Signed port is ignored (all unsigned).
// Ports   : CLK       - clock, all state updates on rising edge
//           RESET     - synchronous active-high reset
//           Start     - operation request (already condition-gated)
//           MCycleOp  - 0 = multiply, 1 = divide
//           Signed    - signed operation request
//           Operand1  - multiplicand / dividend
//           Operand2  - multiplier / divisor
//           Result1   - product low half / quotient
//           Result2   - product high half / remainder
//           Busy      - pipeline stall request (combinational)
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;      // latched MCycleOp
    logic [WIDTH-1:0] r_hi;       // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;       // multiplier / quotient shift register
    logic [WIDTH-1:0] r_m;        // multiplicand / divisor magnitude
    logic             r_neg_q;    // negate product or quotient at the end
    logic             r_neg_r;    // negate remainder at the end
    logic             r_div0;     // divisor was zero
    logic [WIDTH-1:0] r_op1;      // original dividend for divide-by-zero result
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_res2;

    logic             w_sgn;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

`ifdef MCYCLE_SIGNED_EN
    assign w_sgn = Signed;
`else
    assign w_sgn = Signed & 1'b0;
`endif

    // Operands are reduced to magnitudes; signs are reapplied on the last iteration.
    assign w_s1   = w_sgn & Operand1[WIDTH-1];
    assign w_s2   = w_sgn & Operand2[WIDTH-1];
    assign w_mag1 = w_s1 ? -Operand1 : Operand1;
    assign w_mag2 = w_s2 ? -Operand2 : Operand2;

    // Shift-add: add multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole {carry, hi, lo} right by one.
    assign w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_mul_hi = w_add[WIDTH:1];
    assign w_mul_lo = {w_add[0], r_lo[WIDTH-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always "fits", so the
    // quotient fills with ones and the remainder ends as the dividend magnitude.
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_m};
    assign w_diff   = w_shift[WIDTH-1:0] - r_m;
    assign w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    // Sign-corrected final values, valid on the last iteration only.
    assign w_prod = r_neg_q ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};
    assign w_q    = r_neg_q ? -w_div_lo : w_div_lo;
    assign w_r    = r_neg_r ? -w_div_hi : w_div_hi;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_op1   <= '0;
            r_res1  <= '0;
            r_res2  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state <= COMPUTING;
                        r_cnt   <= '0;
                        r_div   <= MCycleOp;
                        r_hi    <= '0;
                        r_lo    <= w_mag1;
                        r_m     <= w_mag2;
                        r_neg_q <= w_s1 ^ w_s2;
                        r_neg_r <= w_s1;
                        r_div0  <= (Operand2 == '0);
                        r_op1   <= Operand1;
                    end
                end
                COMPUTING: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_hi  <= r_div ? w_div_hi : w_mul_hi;
                    r_lo  <= r_div ? w_div_lo : w_mul_lo;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= DONE;
                        if (!r_div) begin
                            r_res1 <= w_prod[WIDTH-1:0];
                            r_res2 <= w_prod[2*WIDTH-1:WIDTH];
                        end else if (r_div0) begin
                            r_res1 <= '1;
                            r_res2 <= r_op1;
                        end else begin
                            r_res1 <= w_q;
                            r_res2 <= w_r;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy    = !RESET && (((r_state == IDLE) && Start) || (r_state == COMPUTING));
    assign Result1 = r_res1;
    assign Result2 = r_res2;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - scoreboard testbench for mcycle_unit
module tb_mcycle_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic         MCycleOp;
    logic         Signed;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Signed   (Signed),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   busy_run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic sgn,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        logic   sg;
        int     ia, ib;
        longint sa, sb_, q, r, p;
`ifdef MCYCLE_SIGNED_EN
        sg = sgn;
`else
        sg = 1'b0 & sgn;
`endif
        ia = a;
        ib = b;
        sa = ia;
        sb_ = ib;
        if (!op) begin
            if (sg) p = sa * sb_;
            else    p = {32'd0, a} * {32'd0, b};
            e.r1 = p[31:0];
            e.r2 = p[63:32];
        end else if (b == 0) begin
            e.r1 = '1;
            e.r2 = a;
        end else if (sg) begin
            q = sa / sb_;
            r = sa % sb_;
            e.r1 = q[31:0];
            e.r2 = r[31:0];
        end else begin
            e.r1 = a / b;
            e.r2 = a % b;
        end
        return e;
    endfunction

    // Result monitor: a falling Busy outside reset marks the DONE cycle.
    always @(negedge CLK) begin
        if (RESET) begin
            busy_run = 0;
        end else if (Busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            chk("busy_len", 64'(busy_run), 64'(W + 1));
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result1", 64'(Result1), 64'(e.r1));
                chk("result2", 64'(Result2), 64'(e.r2));
            end
            n_done++;
            busy_run = 0;
        end
    end

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (n_done < target) chk("timeout", 64'(n_done), 64'(target));
    endtask

    task automatic do_op(input logic op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int target;
        target = n_done + 1;
        sb.push_back(model(op, sgn, a, b));
        @(posedge CLK);
        #2;
        Start    = 1'b1;
        MCycleOp = op;
        Signed   = sgn;
        Operand1 = a;
        Operand2 = b;
        @(posedge CLK);
        #2;
        // Operand and mode changes while computing must not disturb the result.
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = ~op;
        Signed   = ~sgn;
        wait_done(target);
    endtask

    initial begin
        RESET    = 1'b1;
        Start    = 1'b1;
        MCycleOp = 1'b0;
        Signed   = 1'b0;
        Operand1 = 32'd3;
        Operand2 = 32'd4;
        @(negedge CLK);
        chk("rst_busy", 64'(Busy), 64'd0);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        Start = 1'b0;
        @(negedge CLK);
        chk("rst_r1", 64'(Result1), 64'd0);
        chk("rst_r2", 64'(Result2), 64'd0);
        chk("idle_busy", 64'(Busy), 64'd0);

        do_op(1'b0, 1'b0, 32'd7, 32'd6);
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b0, 32'd100, 32'd7);
        do_op(1'b1, 1'b0, 32'd5, 32'd0);
        do_op(1'b0, 1'b1, -32'sd7, 32'd3);
        do_op(1'b1, 1'b1, -32'sd7, 32'd2);
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b1, -32'sd5, 32'd0);
        do_op(1'b1, 1'b1, 32'd17, -32'sd5);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);

        // Start held high: one operation, DONE ignores it, next starts in IDLE.
        begin
            int base;
            base = n_done;
            sb.push_back(model(1'b0, 1'b0, 32'd12345, 32'd678));
            sb.push_back(model(1'b0, 1'b0, 32'd12345, 32'd678));
            @(posedge CLK);
            #2;
            Start    = 1'b1;
            MCycleOp = 1'b0;
            Signed   = 1'b0;
            Operand1 = 32'd12345;
            Operand2 = 32'd678;
            wait_done(base + 1);
            @(negedge CLK);
            chk("hold_restart_busy", 64'(Busy), 64'd1);
            @(posedge CLK);
            #2;
            Start = 1'b0;
            wait_done(base + 2);
        end

        // Reset in the 10th computing cycle aborts with results cleared.
        begin
            @(posedge CLK);
            #2;
            Start    = 1'b1;
            MCycleOp = 1'b1;
            Signed   = 1'b0;
            Operand1 = 32'd100;
            Operand2 = 32'd7;
            @(posedge CLK);
            #2;
            Start = 1'b0;
            repeat (9) @(posedge CLK);
            #2;
            RESET = 1'b1;
            @(negedge CLK);
            chk("abort_busy_in_reset", 64'(Busy), 64'd0);
            @(posedge CLK);
            #2;
            RESET = 1'b0;
            @(negedge CLK);
            chk("abort_busy", 64'(Busy), 64'd0);
            chk("abort_r1", 64'(Result1), 64'd0);
            chk("abort_r2", 64'(Result2), 64'd0);
        end
        do_op(1'b1, 1'b0, 32'd9, 32'd3);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i == 3) ? 32'd0 : (i[0] ? 32'($urandom_range(1, 1000)) : $urandom);
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
        end

        repeat (3) @(posedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits; legal values 8..32.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  operation request; already gated by the condition check (MCycleS AND CondEx).
REQ-005 SHALL have port MCycleOp  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port Signed  input  1  1 = signed operation; honoured only per REQ-026.
REQ-007 SHALL have port Operand1  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port Operand2  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have port Result1  output  WIDTH  product low half or quotient.
REQ-010 SHALL have port Result2  output  WIDTH  product high half or remainder.
REQ-011 SHALL have port Busy  output  1  stall request to the pipeline/PC.

Function
REQ-012 SHALL implement an FSM with states IDLE, COMPUTING and DONE.
REQ-013 IDLE: Start=1 at a rising edge SHALL latch Operand1, Operand2, MCycleOp and Signed, clear the iteration counter and enter COMPUTING; Start=0 SHALL keep IDLE.
REQ-014 COMPUTING SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle, for WIDTH iterations.
REQ-015 On the edge completing iteration WIDTH-1, the FSM SHALL register Result1/Result2 and enter DONE.
REQ-016 DONE SHALL last exactly one cycle, ignore Start, and return to IDLE.
REQ-017 Busy SHALL be combinational: 1 when (IDLE and Start=1) or COMPUTING; 0 in DONE and in IDLE with Start=0.
REQ-018 Busy SHALL therefore be high for exactly WIDTH+1 consecutive cycles per operation, starting in the cycle Start first rises.
REQ-019 Start and operand changes during COMPUTING or DONE SHALL be ignored.
REQ-020 Result1/Result2 SHALL hold their last value from the end of one operation until the end of the next, and SHALL not show intermediate values.
REQ-021 Multiply: {Result2, Result1} SHALL equal the full 2*WIDTH-bit product.
REQ-022 Divide: Result1 = quotient, Result2 = remainder, with Operand1 = Result1*Operand2 + Result2.
REQ-023 Divide by zero: Result1 SHALL be all ones and Result2 SHALL equal Operand1, in both signed and unsigned modes, with normal latency.

Reset
REQ-024 RESET=1 at a rising edge SHALL force IDLE, clear the counter and internal registers, and set Result1=0 and Result2=0; Busy SHALL be 0 while RESET=1.
REQ-025 RESET during COMPUTING SHALL abort the operation with no result update; RESET has priority over Start.

Configuration
REQ-026 With macro MCYCLE_SIGNED_EN defined, Signed=1 SHALL give two's-complement operation (operands converted to magnitude, results sign-corrected; quotient truncates toward zero, remainder takes the dividend's sign; most-negative divided by -1 gives quotient most-negative, remainder 0); without it, the Signed port SHALL exist but be ignored, and all operations SHALL be unsigned.

Verification
REQ-027 Unsigned multiply, WIDTH=32: 7 x 6 -> Result1=42, Result2=0; Busy high 33 cycles, then one DONE cycle with Busy=0.
REQ-028 Unsigned multiply: 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE.
REQ-029 Unsigned divide 100 / 7 -> Result1=14, Result2=2; divide 5 / 0 -> Result1=0xFFFFFFFF, Result2=5.
REQ-030 With MCYCLE_SIGNED_EN: signed -7 x 3 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF; signed -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; same stimulus without the macro -> unsigned results.
REQ-031 Start held high continuously across one operation -> exactly one operation runs; DONE does not restart; a new operation starts at the first IDLE cycle.
REQ-032 RESET asserted in the 10th COMPUTING cycle -> Busy=0 and Result1=Result2=0 on the next cycle; a following 9 / 3 divide yields 3, 0.
